// File: rtl/led_sequence_player.sv
// led_sequence_player: plays ROM entries 0..limite on 4 LEDs, each lit T_ON clocks then dark T_OFF clocks.
// Latency: first LED value 2 clocks after the start-accept edge; 2+T_ON+T_OFF clocks per entry.
// Backpressure: none; iniciar is ignored while busy, parar aborts to IDLE on the next edge.
//
// Ports:
//   clock, reset     single clock, synchronous active-high reset
//   iniciar, parar   start request (IDLE only) / abort (any state, wins over iniciar)
//   limite           last ROM address to play, captured when a start is accepted
//   rom_data         synchronous ROM output, valid one edge after rom_addr settles
//   rom_addr, leds   registered ROM address and LED drive
//   ocupado, pronto  busy flag (FETCH..GAP) / one-cycle completion pulse (DONE)
module led_sequence_player #(
  parameter int T_ON  = 4,
  parameter int T_OFF = 2,
  parameter int CNT_W = 16
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       iniciar,
  input  logic       parar,
  input  logic [3:0] limite,
  input  logic [3:0] rom_data,
  output logic [3:0] rom_addr,
  output logic [3:0] leds,
  output logic       ocupado,
  output logic       pronto
);

  typedef enum logic [2:0] {IDLE, FETCH, LOAD, SHOW, GAP, DONE} state_t;

  localparam logic [CNT_W-1:0] ON_LAST  = CNT_W'(T_ON - 1);
  localparam logic [CNT_W-1:0] OFF_LAST = CNT_W'(T_OFF - 1);

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [3:0]       lim_reg, lim_nxt;
  logic [3:0]       addr_nxt, leds_nxt;

  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= IDLE;
      cnt      <= '0;
      lim_reg  <= '0;
      rom_addr <= '0;
      leds     <= '0;
    end else begin
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      lim_reg  <= lim_nxt;
      rom_addr <= addr_nxt;
      leds     <= leds_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    lim_nxt   = lim_reg;
    addr_nxt  = rom_addr;
    leds_nxt  = leds;

    if (parar) begin
      // Abort keeps rom_addr so the last position played stays visible.
      state_nxt = IDLE;
      leds_nxt  = '0;
      cnt_nxt   = '0;
    end else begin
      case (state)
        IDLE: begin
          leds_nxt = '0;
          if (iniciar) begin
            lim_nxt   = limite;
            addr_nxt  = '0;
            cnt_nxt   = '0;
            state_nxt = FETCH;
          end
        end
        // Address is stable here; the ROM captures it on the exit edge.
        FETCH: state_nxt = LOAD;
        LOAD: begin
          leds_nxt  = rom_data;
          cnt_nxt   = '0;
          state_nxt = SHOW;
        end
        SHOW: begin
          if (cnt == ON_LAST) begin
            leds_nxt  = '0;
            cnt_nxt   = '0;
            state_nxt = GAP;
          end else begin
            cnt_nxt = cnt + CNT_W'(1);
          end
        end
        GAP: begin
          if (cnt == OFF_LAST) begin
            cnt_nxt = '0;
            // No wrap: stopping on lim_reg lets limite=15 cover all 16 entries.
            if (rom_addr == lim_reg) begin
              state_nxt = DONE;
            end else begin
              addr_nxt  = rom_addr + 4'd1;
              state_nxt = FETCH;
            end
          end else begin
            cnt_nxt = cnt + CNT_W'(1);
          end
        end
        DONE:    state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  assign ocupado = (state == FETCH) || (state == LOAD) || (state == SHOW) || (state == GAP);
  assign pronto  = (state == DONE);

endmodule

// File: tb/tb_led_sequence_player.sv
module tb_led_sequence_player;

  localparam int T_ON  = 4;
  localparam int T_OFF = 2;
  localparam int P     = 2 + T_ON + T_OFF;

  logic       clock = 1'b0;
  logic       reset;
  logic       iniciar;
  logic       parar;
  logic [3:0] limite;
  logic [3:0] rom_data;
  logic [3:0] rom_addr;
  logic [3:0] leds;
  logic       ocupado;
  logic       pronto;

  logic [3:0] rom [16];
  int errors = 0;
  int checks = 0;
  logic [3:0] cur_addr;

  led_sequence_player #(.T_ON(T_ON), .T_OFF(T_OFF), .CNT_W(16)) dut (
    .clock(clock), .reset(reset), .iniciar(iniciar), .parar(parar),
    .limite(limite), .rom_data(rom_data), .rom_addr(rom_addr),
    .leds(leds), .ocupado(ocupado), .pronto(pronto)
  );

  always #5 clock = ~clock;

  // Synchronous ROM: data appears one edge after the address.
  always @(posedge clock) rom_data <= rom[rom_addr];

  typedef struct {
    int         lim;
    int         abort_at;   // 0 = none, else cycle in which abort is held
    bit         use_rst;    // abort via reset instead of parar
    bit         hold;       // keep iniciar high through the run
    int         exp_busy;
    int         exp_pr_cyc; // 0 = pronto never seen
    logic [3:0] exp_end;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Expected {ocupado, pronto, rom_addr, leds} in cycle c after the accept edge.
  function automatic logic [9:0] model(input int lim, input int c);
    int b, k, ph;
    logic [3:0] lv;
    b = (lim + 1) * P;
    if (c <= b) begin
      k  = (c - 1) / P;
      ph = (c - 1) % P;
      lv = (ph >= 2 && ph < 2 + T_ON) ? rom[k] : 4'b0000;
      return {1'b1, 1'b0, 4'(k), lv};
    end
    return {1'b0, 1'b1, 4'(lim), 4'b0000};
  endfunction

  task automatic run(input string tag, input int lim, input int abort_at, input bit use_rst,
                     input bit hold, output int busy, output int pr_cyc, output logic [3:0] end_addr);
    int b;
    logic [9:0] obs, exp;
    logic [3:0] ab_addr;
    b = (lim + 1) * P;
    busy = 0;
    pr_cyc = 0;
    ab_addr = 4'd0;
    end_addr = 4'(lim);
    iniciar = 1'b1;
    parar = 1'b0;
    limite = 4'(lim);
    @(negedge clock);
    check({tag, "_idle_before"}, 32'({ocupado, pronto, rom_addr, leds}), 32'({2'b00, cur_addr, 4'b0000}));
    tick();
    for (int c = 1; c <= b + 1; c++) begin
      iniciar = hold;
      limite = 4'($urandom);
      parar = (c == abort_at) && !use_rst;
      reset = (c == abort_at) && use_rst;
      @(negedge clock);
      obs = {ocupado, pronto, rom_addr, leds};
      if (abort_at != 0 && c == abort_at + 1) exp = {2'b00, ab_addr, 4'b0000};
      else exp = model(lim, c);
      if (c == abort_at) begin
        ab_addr  = use_rst ? 4'd0 : exp[7:4];
        end_addr = ab_addr;
      end
      check({tag, "_cycle"}, 32'(obs), 32'(exp));
      if (ocupado) busy++;
      if (pronto) pr_cyc = c;
      tick();
      if (abort_at != 0 && c == abort_at + 1) break;
    end
    parar = 1'b0;
    reset = 1'b0;
    limite = 4'(lim);
  endtask

  vec_t vecs [9];
  int busy, pr_cyc;
  logic [3:0] end_addr;
  logic [3:0] exp_leds1 [24];

  initial begin
    for (int i = 0; i < 16; i++) rom[i] = 4'(i);
    rom[0] = 4'b0001; rom[1] = 4'b0010; rom[2] = 4'b0100; rom[3] = 4'b0000; rom[15] = 4'b0100;

    vecs[0] = '{2,  0,  0, 0, 24,  25,  4'd2};
    vecs[1] = '{0,  0,  0, 0, 8,   9,   4'd0};
    vecs[2] = '{15, 0,  0, 0, 128, 129, 4'd15};
    vecs[3] = '{2,  12, 0, 0, 12,  0,   4'd1};   // parar in 2nd SHOW
    vecs[4] = '{1,  0,  0, 1, 16,  17,  4'd1};   // iniciar held
    vecs[5] = '{1,  0,  0, 0, 16,  17,  4'd1};   // restart from held iniciar
    vecs[6] = '{2,  7,  1, 0, 7,   0,   4'd0};   // reset in first GAP
    vecs[7] = '{2,  0,  0, 0, 24,  25,  4'd2};
    vecs[8] = '{3,  0,  0, 0, 32,  33,  4'd3};   // includes a dark entry

    exp_leds1 = '{4'h0, 4'h0, 4'h1, 4'h1, 4'h1, 4'h1, 4'h0, 4'h0,
                  4'h0, 4'h0, 4'h2, 4'h2, 4'h2, 4'h2, 4'h0, 4'h0,
                  4'h0, 4'h0, 4'h4, 4'h4, 4'h4, 4'h4, 4'h0, 4'h0};

    reset = 1'b1; iniciar = 1'b0; parar = 1'b0; limite = 4'd0;
    tick(); tick();
    reset = 1'b0;
    @(negedge clock);
    check("reset_state", 32'({ocupado, pronto, rom_addr, leds}), 32'(0));
    cur_addr = 4'd0;
    tick();

    // iniciar and parar together in IDLE: stays idle.
    iniciar = 1'b1; parar = 1'b1; limite = 4'd2;
    tick();
    iniciar = 1'b0; parar = 1'b0;
    @(negedge clock);
    check("start_with_abort", 32'({ocupado, pronto, rom_addr, leds}), 32'(0));
    tick();

    // Literal LED trace for limite=2.
    iniciar = 1'b1; limite = 4'd2;
    tick();
    iniciar = 1'b0;
    for (int c = 1; c <= 24; c++) begin
      @(negedge clock);
      check("trace_leds", 32'(leds), 32'(exp_leds1[c-1]));
      check("trace_busy", 32'({ocupado, pronto}), 32'(2'b10));
      tick();
    end
    @(negedge clock);
    check("trace_pronto", 32'({ocupado, pronto, rom_addr}), 32'({2'b01, 4'd2}));
    tick();
    cur_addr = 4'd2;

    for (int i = 0; i < 9; i++) begin
      run($sformatf("vec%0d", i), vecs[i].lim, vecs[i].abort_at, vecs[i].use_rst,
          vecs[i].hold, busy, pr_cyc, end_addr);
      check($sformatf("vec%0d_busy", i), 32'(busy), 32'(vecs[i].exp_busy));
      check($sformatf("vec%0d_pronto_cycle", i), 32'(pr_cyc), 32'(vecs[i].exp_pr_cyc));
      check($sformatf("vec%0d_end_addr", i), 32'(rom_addr), 32'(vecs[i].exp_end));
      cur_addr = end_addr;
    end

    for (int i = 0; i < 25; i++) begin
      int lim, ab, b;
      bit ur;
      lim = $urandom_range(0, 7);
      b = (lim + 1) * P;
      ab = ($urandom_range(0, 1) == 1) ? $urandom_range(1, b) : 0;
      ur = ($urandom_range(0, 3) == 0);
      run("rand", lim, ab, ur, 1'b0, busy, pr_cyc, end_addr);
      cur_addr = end_addr;
    end

    iniciar = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
